// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single data RAM port.
// Accepts one access at a time, waits the fixed RAM read latency, then reports completion.
module mem_port_arbiter #(
  parameter int RAM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [2:0]  bhw0,
  input  logic [2:0]  bhw1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] ram_addra,
  output logic [31:0] ram_dina,
  output logic        ram_wea,
  output logic [2:0]  ram_u_b_h_w,
  input  logic [31:0] ram_douta
);

  localparam int CW = $clog2(RAM_LAT + 2);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic        owner_q, owner_d;
  logic        load_q, load_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [31:0] addr_q, addr_d, dina_q, dina_d;
  logic        wea_q, wea_d;
  logic [2:0]  bhw_q, bhw_d;
  logic        win;

  // Winner when both request is the priority port; otherwise the lone requester.
  assign win = (req0 & req1) ? prio_q : req1;

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    load_d   = load_q;
    cnt_d    = cnt_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    addr_d   = addr_q;
    dina_d   = dina_q;
    wea_d    = wea_q;
    bhw_d    = bhw_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          addr_d  = win ? addr1  : addr0;
          dina_d  = win ? wdata1 : wdata0;
          wea_d   = win ? we1    : we0;
          bhw_d   = win ? bhw1   : bhw0;
          load_d  = ~(win ? we1 : we0);
          gnt0_d  = ~win;
          gnt1_d  = win;
          owner_d = win;
          prio_d  = ~win;
          cnt_d   = CW'(RAM_LAT + 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        // The write enable lives for the accepting cycle only, so a store lands once.
        wea_d = 1'b0;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          if (load_q) begin
            if (owner_q) rdata1_d = ram_douta;
            else         rdata0_d = ram_douta;
          end
          done0_d = ~owner_q;
          done1_d = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      load_q   <= 1'b0;
      cnt_q    <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      addr_q   <= '0;
      dina_q   <= '0;
      wea_q    <= 1'b0;
      bhw_q    <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      load_q   <= load_d;
      cnt_q    <= cnt_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      addr_q   <= addr_d;
      dina_q   <= dina_d;
      wea_q    <= wea_d;
      bhw_q    <= bhw_d;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign ram_addra   = addr_q;
  assign ram_dina    = dina_q;
  assign ram_wea     = wea_q;
  assign ram_u_b_h_w = bhw_q;

endmodule
